// File: rtl/led_pattern_ctrl_if.sv
// led_pattern_if: control inputs and LED outputs of the LED ring sequencer
interface led_pattern_if #(parameter int WIDTH = 8);
    logic             en;
    logic [1:0]       mode;
    logic [1:0]       speed;
    logic             step;
    logic [WIDTH-1:0] led;
    logic             step_pulse;
    logic             busy;
    modport master (output en, mode, speed, step, input led, step_pulse, busy);
    modport slave  (input en, mode, speed, step, output led, step_pulse, busy);
endinterface

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: run/pause LED ring sequencer with step prescaler; LED_PATTERN_PINGPONG_EN enables ping-pong mode 2
module led_pattern_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DIV_BASE = 25_000_000
) (
    input logic          clk,
    input logic          rst_n,
    led_pattern_if.slave bus
);
    localparam int CW = $clog2(DIV_BASE);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] led_q, led_nx;
    logic [1:0]       mode_q;
    logic [31:0]      per_m1;
    logic             upd, busy_q, pulse_q;
`ifdef LED_PATTERN_PINGPONG_EN
    logic             dir, dir_nx;
`endif
    assign per_m1 = (32'(DIV_BASE) >> bus.speed) - 32'd1;
    // >= rather than == so a shortened period mid-count steps at once instead of wrapping
    assign upd = (state == RUN) ? (bus.en && 32'(cnt) >= per_m1) : (!bus.en && bus.step);
    assign bus.led        = led_q;
    assign bus.step_pulse = pulse_q;
    assign bus.busy       = busy_q;
    // next pattern: a mode change reloads the seed, otherwise advance by the latched mode
    always_comb begin
        led_nx = led_q;
`ifdef LED_PATTERN_PINGPONG_EN
        dir_nx = dir;
`endif
        if (bus.mode != mode_q) begin
            led_nx = WIDTH'(1);
`ifdef LED_PATTERN_PINGPONG_EN
            dir_nx = 1'b1;
`endif
        end
        else if (mode_q == 2'd3)
            led_nx = &led_q ? WIDTH'(1) : {led_q[WIDTH-2:0], 1'b1};
        else if (mode_q == 2'd1)
            led_nx = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
`ifdef LED_PATTERN_PINGPONG_EN
        else if (mode_q == 2'd2) begin
            led_nx = dir ? led_q << 1 : led_q >> 1;
            dir_nx = dir ? !led_nx[WIDTH-1] : led_nx[0];
        end
`endif
        else
            led_nx = {led_q[0], led_q[WIDTH-1:1]};
    end
    // run/pause FSM, prescaler and registered pattern outputs; every state goes to RUN exactly when en is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            led_q   <= WIDTH'(1);
            mode_q  <= 2'd0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef LED_PATTERN_PINGPONG_EN
            dir     <= 1'b1;
`endif
        end else begin
            state   <= bus.en ? RUN : (state == IDLE && !bus.step) ? IDLE : PAUSE;
            busy_q  <= bus.en;
            pulse_q <= upd;
            if (state == RUN && bus.en)
                cnt <= upd ? '0 : cnt + 1'b1;
            if (upd) begin
                led_q  <= led_nx;
                mode_q <= bus.mode;
`ifdef LED_PATTERN_PINGPONG_EN
                dir    <= dir_nx;
`endif
            end
        end
    end
endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

- Sequences an 8-bit LED ring: a run/pause state machine, a programmable step-rate prescaler and a pattern generator (rotate right, rotate left, ping-pong, fill bar).
- Replaces the free-running rotator that advanced on every clock.
- Sits between the board clock and the LED pins; switches and buttons drive `mode`, `speed`, `en` and `step`.

## Interface

- `WIDTH`, 8: LED count; must be ≥ 2.
- `DIV_BASE`, 25_000_000: clocks per step at `speed`=0; must be ≥ 8.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  level; 1 = free-run, 0 = pause.
- `mode`  in  2  0 rotate right, 1 rotate left, 2 ping-pong, 3 fill bar.
- `speed`  in  2  step period = `DIV_BASE >> speed` clocks.
- `step`  in  1  synchronous one-cycle pulse; single-step while not running.
- `led`  out  WIDTH  current pattern (registered).
- `step_pulse`  out  1  high for exactly one cycle, coincident with each new `led` value.
- `busy`  out  1  high while in RUN.

## Operation

**Reset (async)**
- `led` = 1 (bit 0 set); `step_pulse` = 0; `busy` = 0.
- Prescaler = 0; `dir` = up (toward MSB); `mode_q` = 0; state = IDLE.
- Reset mid-run aborts immediately, with no partial step.

**States**
- IDLE → RUN when `en`=1.
- IDLE → PAUSE on `step`=1 with `en`=0; performs one update.
- RUN → PAUSE when `en`=0; prescaler freezes and `led` holds.
- PAUSE → RUN when `en`=1; prescaler resumes from its frozen count.
- PAUSE + `step` with `en`=0: one update, stays in PAUSE.
- `step` is ignored in RUN.
- `en` rising together with `step`: `en` wins, `step` is ignored.

**Prescaler (RUN only)**
- Period P = `DIV_BASE >> speed`.
- Each clock: if count ≥ P−1, count ← 0 and update; else count+1.
- The ≥ compare makes a mid-count speed decrease step on the next clock, never wrap.

**Update rules**
- `mode` is sampled into `mode_q` only at an update.
- If `mode` ≠ `mode_q`: `led` ← 1, `dir` ← up, `mode_q` ← `mode`. This counts as the update.
- Otherwise, by `mode_q`:
  - 0: `led` ← {led[0], led[W−1:1]}.
  - 1: `led` ← {led[W−2:0], led[W−1]}.
  - 2: if `dir`=up, `led`<<1; on reaching MSB set `dir`=down. If `dir`=down, `led`>>1; on reaching bit 0 set `dir`=up. Period 2W−2 steps, no repeat at the ends.
  - 3: if `led` all ones, `led` ← 1; else `led` ← {led[W−2:0], 1'b1}. Period W steps.
- `step_pulse` is asserted on every update, including mode-change reloads.

## Timing

- Update condition true at edge k: new `led` and `step_pulse`=1 are visible after edge k. One clock, no extra latency.
- RUN from count 0: first update at the P-th clock edge after entering RUN, then every P clocks.
- `step` seen at edge k in IDLE or PAUSE: `led` changes after edge k.
- `busy` follows the state register, same edge as the transition.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration

- `LED_PATTERN_PINGPONG_EN` defined: mode 2 is ping-pong as above, and the `dir` register is present.
- Undefined: `dir` logic is removed and mode 2 behaves exactly as mode 0 (rotate right).
- Mode-change reload still applies between 0 and 2 in both builds, because `mode_q` differs.

## Test plan

- Reset, then `en`=1, `DIV_BASE`=8, `speed`=0, `mode`=0: first `step_pulse` 8 clocks after RUN, `led`=0x01 reload (`mode_q` already 0, so 0x80), then 0x40, 0x20… every 8 clocks.
- `mode`=2 with macro defined, 16 steps: `led` = 01,02,04,…,80,40,…,01,02; no duplicate at 0x80 or 0x01. Without macro: same as rotate right.
- `mode`=3: 01→03→07→…→FF→01; `step_pulse` count equals updates.
- Pause/step: run to `led`=0x20, `en`=0, two `step` pulses → 0x10 then 0x08, `busy`=0. `en`=1 resumes the frozen count: next update at P−(frozen count) clocks.
- Speed 0→3 with count=6 (P 8→1): update on the next edge, then every clock. Mode change 0→1 mid-run: next update gives `led`=0x01, then 0x02.
- `rst_n` low mid-run at `led`=0x10: outputs immediately 0x01/0/0; after release, state is IDLE and `led` holds 0x01 until `en` or `step`.
